// File: rtl/serdiv_result_buffer_pkg.sv
// rtl/serdiv_result_buffer_pkg.sv - shared widths and result record for the divider result buffer
package serdiv_result_buffer_pkg;

    // Transaction id width used across the pipeline.
    localparam int TRANS_ID_BITS = 3;

    // Result width of the serial divider.
    localparam int RES_WIDTH = 8;

    // One completed divide result as it travels to writeback.
    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [RES_WIDTH-1:0]     res;
        logic                     label;
    } serdiv_res_t;

endpackage

// File: rtl/serdiv_result_buffer_if.sv
// rtl/serdiv_result_buffer_if.sv - divider-side and writeback-side signals of the result buffer (SERDIV_RESBUF_LABEL_MASK_EN adds mask_tainted_i)
interface serdiv_result_buffer_if
    import serdiv_result_buffer_pkg::*;
#(
    parameter int WIDTH = RES_WIDTH,
    parameter int DEPTH = 2
);
    logic                       flush_i;
    logic                       div_vld_i;
    logic                       div_rdy_o;
    logic [TRANS_ID_BITS-1:0]   div_id_i;
    logic [WIDTH-1:0]           div_res_i;
    logic                       div_label_i;
    logic                       wb_vld_o;
    logic                       wb_rdy_i;
    logic [TRANS_ID_BITS-1:0]   wb_id_o;
    logic [WIDTH-1:0]           wb_res_o;
    logic                       wb_label_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       taint_pend_o;
`ifdef SERDIV_RESBUF_LABEL_MASK_EN
    logic                       mask_tainted_i;
`endif

    modport master (
        output flush_i, div_vld_i, div_id_i, div_res_i, div_label_i, wb_rdy_i,
`ifdef SERDIV_RESBUF_LABEL_MASK_EN
        output mask_tainted_i,
`endif
        input  div_rdy_o, wb_vld_o, wb_id_o, wb_res_o, wb_label_o, count_o, taint_pend_o
    );

    modport slave (
        input  flush_i, div_vld_i, div_id_i, div_res_i, div_label_i, wb_rdy_i,
`ifdef SERDIV_RESBUF_LABEL_MASK_EN
        input  mask_tainted_i,
`endif
        output div_rdy_o, wb_vld_o, wb_id_o, wb_res_o, wb_label_o, count_o, taint_pend_o
    );

endinterface

// File: rtl/serdiv_resbuf_mem.sv
// rtl/serdiv_resbuf_mem.sv - DEPTH-entry result storage with one write port and one read address
module serdiv_resbuf_mem #(
    parameter int DW    = 12,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Write the accepted entry; reset clears storage so the head reads zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/serdiv_result_buffer.sv
// rtl/serdiv_result_buffer.sv - in-order FIFO between serial divider and writeback (SERDIV_RESBUF_LABEL_MASK_EN enables output masking of tainted results)
module serdiv_result_buffer
    import serdiv_result_buffer_pkg::*;
#(
    parameter int WIDTH = RES_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    serdiv_result_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = TRANS_ID_BITS + WIDTH + 1;

    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, count_d;
    logic [DEPTH-1:0] lbl_q, lbl_d;
    logic             taint_q, wb_vld_q;
    logic             div_rdy, push, pop;
    logic [DW-1:0]    rdata;

    // Ready depends only on the registered count, never on wb_rdy_i.
    assign div_rdy = (count != CW'(DEPTH));
    assign push    = bus.div_vld_i && div_rdy;
    assign pop     = wb_vld_q && bus.wb_rdy_i;

    // Next count and per-slot label occupancy; flush overrides both push and pop.
    always_comb begin
        count_d = count;
        lbl_d   = lbl_q;
        if (bus.flush_i) begin
            count_d = '0;
            lbl_d   = '0;
        end else begin
            count_d = count + CW'(push) - CW'(pop);
            if (pop)  lbl_d[rd_ptr] = 1'b0;
            if (push) lbl_d[wr_ptr] = bus.div_label_i;
        end
    end

    // Pointer, count, valid and taint registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            lbl_q    <= '0;
            taint_q  <= 1'b0;
            wb_vld_q <= 1'b0;
        end else begin
            count    <= count_d;
            lbl_q    <= lbl_d;
            taint_q  <= |lbl_d;
            wb_vld_q <= (count_d != '0);
            if (bus.flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push) wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    serdiv_resbuf_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (push && !bus.flush_i),
        .waddr (wr_ptr),
        .wdata ({bus.div_id_i, bus.div_res_i, bus.div_label_i}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.div_rdy_o    = div_rdy;
    assign bus.wb_vld_o     = wb_vld_q;
    assign bus.count_o      = count;
    assign bus.taint_pend_o = taint_q;
    assign bus.wb_id_o      = rdata[DW-1 -: TRANS_ID_BITS];
    assign bus.wb_label_o   = rdata[0];
`ifdef SERDIV_RESBUF_LABEL_MASK_EN
    assign bus.wb_res_o     = (bus.mask_tainted_i && rdata[0]) ? '0 : rdata[WIDTH:1];
`else
    assign bus.wb_res_o     = rdata[WIDTH:1];
`endif

endmodule

// File: tb/tb_serdiv_result_buffer.sv
// tb/tb_serdiv_result_buffer.sv - self-checking bench for serdiv_result_buffer (honours SERDIV_RESBUF_LABEL_MASK_EN)
module tb_serdiv_result_buffer;
    import serdiv_result_buffer_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serdiv_result_buffer_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    serdiv_result_buffer #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       flush, vld;
        logic [2:0] id;
        logic [7:0] res;
        logic       lbl, rdy;
        logic [1:0] e_cnt;
        logic       e_vld, e_drdy, e_taint;
        logic [2:0] e_id;
        logic [7:0] e_res;
        logic       e_lbl;
    } vec_t;

    vec_t        tbl [19];
    serdiv_res_t model_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic fl, logic v, logic [2:0] id, logic [7:0] r, logic l, logic rd,
                                logic [1:0] ec, logic ev, logic edr, logic et,
                                logic [2:0] eid, logic [7:0] er, logic el);
        vec_t t;
        t.flush = fl; t.vld = v; t.id = id; t.res = r; t.lbl = l; t.rdy = rd;
        t.e_cnt = ec; t.e_vld = ev; t.e_drdy = edr; t.e_taint = et;
        t.e_id = eid; t.e_res = er; t.e_lbl = el;
        return t;
    endfunction

    task automatic drive(input logic fl, input logic v, input logic [2:0] id,
                         input logic [7:0] r, input logic l, input logic rd);
        bus.flush_i     = fl;
        bus.div_vld_i   = v;
        bus.div_id_i    = id;
        bus.div_res_i   = r;
        bus.div_label_i = l;
        bus.wb_rdy_i    = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {flush,vld,id,res,lbl,wb_rdy | count,wb_vld,div_rdy,taint,id,res,label} observed before the edge
        tbl[0]  = mk(0,1,3,8'h2A,0,1, 0,0,1,0, 0,8'h00,0);
        tbl[1]  = mk(0,0,0,8'h00,0,1, 1,1,1,0, 3,8'h2A,0);
        tbl[2]  = mk(0,0,0,8'h00,0,0, 0,0,1,0, 0,8'h00,0);
        tbl[3]  = mk(0,1,1,8'h01,0,0, 0,0,1,0, 0,8'h00,0);
        tbl[4]  = mk(0,1,2,8'h02,0,0, 1,1,1,0, 1,8'h01,0);
        tbl[5]  = mk(0,1,3,8'h03,0,0, 2,1,0,0, 1,8'h01,0);
        tbl[6]  = mk(0,1,3,8'h03,0,1, 2,1,0,0, 1,8'h01,0);
        tbl[7]  = mk(0,1,3,8'h03,0,1, 1,1,1,0, 2,8'h02,0);
        tbl[8]  = mk(0,0,0,8'h00,0,1, 1,1,1,0, 3,8'h03,0);
        tbl[9]  = mk(0,0,0,8'h00,0,0, 0,0,1,0, 0,8'h00,0);
        tbl[10] = mk(0,1,0,8'h10,0,0, 0,0,1,0, 0,8'h00,0);
        tbl[11] = mk(0,1,1,8'h11,1,0, 1,1,1,0, 0,8'h10,0);
        tbl[12] = mk(0,0,0,8'h00,0,1, 2,1,0,1, 0,8'h10,0);
        tbl[13] = mk(0,0,0,8'h00,0,1, 1,1,1,1, 1,8'h11,1);
        tbl[14] = mk(0,0,0,8'h00,0,0, 0,0,1,0, 0,8'h00,0);
        tbl[15] = mk(0,1,2,8'hAA,0,0, 0,0,1,0, 0,8'h00,0);
        tbl[16] = mk(1,1,5,8'hFF,1,1, 1,1,1,0, 2,8'hAA,0);
        tbl[17] = mk(0,0,0,8'h00,0,0, 0,0,1,0, 0,8'h00,0);
        tbl[18] = mk(0,0,0,8'h00,0,0, 0,0,1,0, 0,8'h00,0);

        drive(0,0,0,0,0,0);
`ifdef SERDIV_RESBUF_LABEL_MASK_EN
        bus.mask_tainted_i = 1'b0;
`endif
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count",   32'(bus.count_o), 0);
        chk("rst_wb_vld",  32'(bus.wb_vld_o), 0);
        chk("rst_div_rdy", 32'(bus.div_rdy_o), 1);
        chk("rst_taint",   32'(bus.taint_pend_o), 0);
        chk("rst_wb_res",  32'(bus.wb_res_o), 0);
        next_cycle();

        // Directed table: single push, back-pressure ordering, taint, flush
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].flush, tbl[i].vld, tbl[i].id, tbl[i].res, tbl[i].lbl, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("row%0d_count", i),   32'(bus.count_o),      32'(tbl[i].e_cnt));
            chk($sformatf("row%0d_wb_vld", i),  32'(bus.wb_vld_o),     32'(tbl[i].e_vld));
            chk($sformatf("row%0d_div_rdy", i), 32'(bus.div_rdy_o),    32'(tbl[i].e_drdy));
            chk($sformatf("row%0d_taint", i),   32'(bus.taint_pend_o), 32'(tbl[i].e_taint));
            if (tbl[i].e_vld) begin
                chk($sformatf("row%0d_id", i),  32'(bus.wb_id_o),    32'(tbl[i].e_id));
                chk($sformatf("row%0d_res", i), 32'(bus.wb_res_o),   32'(tbl[i].e_res));
                chk($sformatf("row%0d_lbl", i), 32'(bus.wb_label_o), 32'(tbl[i].e_lbl));
            end
            next_cycle();
        end

        // Reset mid-stream with two entries held
        drive(0,1,1,8'h31,1,0);
        next_cycle();
        drive(0,1,2,8'h32,0,0);
        next_cycle();
        drive(0,0,0,0,0,0);
        @(negedge clk);
        chk("pre_rst_count", 32'(bus.count_o), 2);
        chk("pre_rst_taint", 32'(bus.taint_pend_o), 1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_count",  32'(bus.count_o), 0);
        chk("mid_rst_wb_vld", 32'(bus.wb_vld_o), 0);
        chk("mid_rst_taint",  32'(bus.taint_pend_o), 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_div_rdy", 32'(bus.div_rdy_o), 1);
        chk("post_rst_count",   32'(bus.count_o), 0);
        next_cycle();

`ifdef SERDIV_RESBUF_LABEL_MASK_EN
        // Output masking of a tainted head
        drive(0,1,4,8'h5A,1,0);
        next_cycle();
        drive(0,0,0,0,0,0);
        bus.mask_tainted_i = 1'b1;
        @(negedge clk);
        chk("mask_on_res", 32'(bus.wb_res_o), 0);
        chk("mask_on_lbl", 32'(bus.wb_label_o), 1);
        chk("mask_on_id",  32'(bus.wb_id_o), 4);
        next_cycle();
        bus.mask_tainted_i = 1'b0;
        @(negedge clk);
        chk("mask_off_res", 32'(bus.wb_res_o), 32'h5A);
        next_cycle();
        drive(0,0,0,0,0,1);
        next_cycle();
        drive(0,0,0,0,0,0);
`endif

        // Randomized traffic against a queue model
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic fl, v, l, rd, msk, exp_taint;
            logic [2:0] id;
            logic [7:0] r;
            serdiv_res_t e;
            fl  = ($urandom_range(0, 15) == 0);
            v   = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 2) != 0);
            l   = $urandom_range(0, 1);
            id  = 3'($urandom_range(0, 7));
            r   = 8'($urandom_range(0, 255));
            msk = 1'b0;
`ifdef SERDIV_RESBUF_LABEL_MASK_EN
            msk = $urandom_range(0, 1);
            bus.mask_tainted_i = msk;
`endif
            drive(fl, v, id, r, l, rd);
            @(negedge clk);
            exp_taint = 1'b0;
            foreach (model_q[k]) exp_taint |= model_q[k].label;
            chk("rnd_count",   32'(bus.count_o), 32'(model_q.size()));
            chk("rnd_wb_vld",  32'(bus.wb_vld_o), 32'(model_q.size() != 0));
            chk("rnd_div_rdy", 32'(bus.div_rdy_o), 32'(model_q.size() != DEPTH));
            chk("rnd_taint",   32'(bus.taint_pend_o), 32'(exp_taint));
            if (model_q.size() != 0) begin
                chk("rnd_id",  32'(bus.wb_id_o), 32'(model_q[0].id));
                chk("rnd_lbl", 32'(bus.wb_label_o), 32'(model_q[0].label));
                chk("rnd_res", 32'(bus.wb_res_o),
                    (msk && model_q[0].label) ? 32'h0 : 32'(model_q[0].res));
            end
            if (fl) begin
                model_q.delete();
            end else begin
                logic do_push, do_pop;
                do_push = v && (model_q.size() != DEPTH);
                do_pop  = rd && (model_q.size() != 0);
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    e.id = id; e.res = r; e.label = l;
                    model_q.push_back(e);
                end
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
